// File: rtl/core_in_packer.sv
`default_nettype none
// ============================================================================
// Module   : core_in_packer
// Brief    : Writer-side feeder for the accelerator input FIFO. Packs
//            NUM_CHANNEL_IN consecutive host words (one pixel, channel-major,
//            first word in lane 0) into one wide FIFO word and writes it with a
//            single-cycle strobe that honours ff_full. Counts pixels per
//            WIDTH x HEIGHT frame, pulses frame_done after the last pixel and
//            raises a sticky frame_err when s_last disagrees with the count.
// Ports    : clk, reset (async, active-high)
//            s_data/s_valid/s_ready/s_last : host stream (valid/ready)
//            ff_wdata/ff_wrreq/ff_full      : FIFO write side
//            frame_done, frame_err, pix_count : frame status
// Revision : 1.0 - initial release
// ============================================================================
module core_in_packer #(
    parameter int DWIDTH         = 32,
    parameter int NUM_CHANNEL_IN = 8,
    parameter int WIDTH          = 56,
    parameter int HEIGHT         = 56,
    localparam int PCW = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DWIDTH-1:0]                s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic                             s_last,
    output logic [NUM_CHANNEL_IN*DWIDTH-1:0] ff_wdata,
    output logic                             ff_wrreq,
    input  logic                             ff_full,
    output logic                             frame_done,
    output logic                             frame_err,
    output logic [PCW-1:0]                   pix_count
);

    localparam int c_CW = (NUM_CHANNEL_IN > 1) ? $clog2(NUM_CHANNEL_IN) : 1;
    localparam logic [c_CW-1:0] c_LAST_CH  = c_CW'(NUM_CHANNEL_IN - 1);
    localparam logic [PCW-1:0]  c_LAST_PIX = PCW'(WIDTH * HEIGHT - 1);

    localparam logic [0:0] c_S_FILL  = 1'b0;
    localparam logic [0:0] c_S_WRITE = 1'b1;

    logic [0:0]                       r_state;
    logic [0:0]                       w_state_nxt;
    logic                             r_run;
    logic [c_CW-1:0]                  r_ch_cnt;
    logic [PCW-1:0]                   r_pix_cnt;
    logic [NUM_CHANNEL_IN*DWIDTH-1:0] r_hold;
    logic                             r_frame_done;
    logic                             r_frame_err;

    logic w_ready;
    logic w_wrreq;
    logic w_xfer;
    logic w_pix_end;
    logic w_final_word;
    logic w_early;
    logic w_missing;

    // Transfer classification. "Final word" is the last channel of the last
    // pixel of the frame; s_last anywhere else is an early frame end.
    assign w_xfer       = s_valid && w_ready;
    assign w_pix_end    = w_xfer && (r_ch_cnt == c_LAST_CH);
    assign w_final_word = w_pix_end && (r_pix_cnt == c_LAST_PIX);
    assign w_early      = w_xfer && s_last && !w_final_word;
    assign w_missing    = w_final_word && !s_last;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_FILL: begin
                // An early s_last drops the partial pixel, so no write.
                if (w_pix_end && !w_early) begin
                    w_state_nxt = c_S_WRITE;
                end
            end
            c_S_WRITE: begin
                if (!ff_full) begin
                    w_state_nxt = c_S_FILL;
                end
            end
            default: w_state_nxt = c_S_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // r_run keeps s_ready low while reset is held and for the edge on which
    // it is released, so no word can be taken before the logic is live.
    always_comb begin
        w_ready = 1'b0;
        w_wrreq = 1'b0;
        case (r_state)
            c_S_FILL:  w_ready = r_run;
            c_S_WRITE: w_wrreq = !ff_full;
            default: begin
                w_ready = 1'b0;
                w_wrreq = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: lane capture, counters, frame status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run        <= 1'b0;
            r_ch_cnt     <= '0;
            r_pix_cnt    <= '0;
            r_hold       <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_run <= 1'b1;

            if (w_xfer) begin
                for (int k = 0; k < NUM_CHANNEL_IN; k++) begin
                    if (r_ch_cnt == c_CW'(k)) begin
                        r_hold[k*DWIDTH +: DWIDTH] <= s_data;
                    end
                end
            end

            if (w_early) begin
                r_ch_cnt <= '0;
            end else if (w_xfer) begin
                r_ch_cnt <= (r_ch_cnt == c_LAST_CH) ? '0 : r_ch_cnt + 1'b1;
            end

            // Early end only happens in FILL and strobes only in WRITE, so
            // the two branches never compete.
            if (w_early) begin
                r_pix_cnt <= '0;
            end else if (w_wrreq) begin
                r_pix_cnt <= (r_pix_cnt == c_LAST_PIX) ? '0 : r_pix_cnt + 1'b1;
            end

            r_frame_done <= w_wrreq && (r_pix_cnt == c_LAST_PIX);

            if (w_early || w_missing) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign s_ready    = w_ready;
    assign ff_wrreq   = w_wrreq;
    assign ff_wdata   = r_hold;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign pix_count  = r_pix_cnt;

endmodule
`default_nettype wire

// File: tb/tb_core_in_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_in_packer
// Brief    : Directed self-checking bench for core_in_packer on a 2x2 frame
//            of 8 x 32-bit channels.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_in_packer;

    localparam int DW  = 32;
    localparam int NCH = 8;
    localparam int PCW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DW-1:0]     s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              s_last = 1'b0;
    logic [NCH*DW-1:0] ff_wdata;
    logic              ff_wrreq;
    logic              ff_full = 1'b0;
    logic              frame_done;
    logic              frame_err;
    logic [PCW-1:0]    pix_count;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_wr   = 0;
    int n_done = 0;
    int wr_before = 0;

    core_in_packer #(
        .DWIDTH         (DW),
        .NUM_CHANNEL_IN (NCH),
        .WIDTH          (2),
        .HEIGHT         (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_last     (s_last),
        .ff_wdata   (ff_wdata),
        .ff_wrreq   (ff_wrreq),
        .ff_full    (ff_full),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .pix_count  (pix_count)
    );

    always #5 clk = ~clk;

    // Strobe / pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (ff_wrreq) n_wr++;
        if (frame_done) n_done++;
        if (!reset) begin
            n_cmp++;
            assert (!(ff_wrreq && ff_full)) else begin
                n_err++;
                $error("FAIL wr_while_full: observed wrreq=1 with ff_full=1, required wrreq=0");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, required finish before 100us");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*DW-1:0] pix(input logic [31:0] base, input logic [31:0] stp);
        logic [NCH*DW-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*DW +: DW] = base + k * stp;
        return r;
    endfunction

    // Present one word and hold it until the DUT accepts it (bounded).
    task automatic send(input logic [31:0] d, input logic last);
        bit done;
        done = 1'b0;
        s_data = d;
        s_valid = 1'b1;
        s_last = last;
        for (int i = 0; i < 20 && !done; i++) begin
            if (s_ready) done = 1'b1;
            step();
        end
        check("send_accepted", done, 1);
    endtask

    // Whole pixel with ff_full low; checks the write cycle, then leaves it.
    task automatic send_pixel(input logic [31:0] base, input logic last_end, input string tag);
        for (int k = 0; k < NCH; k++) send(base + k, last_end && (k == NCH - 1));
        s_valid = 1'b0;
        s_last = 1'b0;
        check({tag, "_wrreq"}, ff_wrreq, 1);
        check({tag, "_wdata"}, ff_wdata, pix(base, 1));
        step();
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_s_ready", s_ready, 0);
        check("rst_wrreq", ff_wrreq, 0);
        check("rst_wdata", ff_wdata, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_pix_count", pix_count, 0);
        reset = 1'b0;
        step();
        check("first_ready", s_ready, 1);

        // ---------------- 1: one pixel back-to-back ----------------
        for (int k = 0; k < NCH; k++) send(32'h11 * (k + 1), 1'b0);
        s_valid = 1'b0;
        check("t1_ready_low", s_ready, 0);
        check("t1_wrreq", ff_wrreq, 1);
        check("t1_wdata", ff_wdata, pix(32'h11, 32'h11));
        step();
        check("t1_ready_back", s_ready, 1);
        check("t1_wrreq_off", ff_wrreq, 0);
        check("t1_nwr", n_wr, 1);
        check("t1_pix_count", pix_count, 1);

        // ---------------- 2: FIFO full for 5 cycles ----------------
        ff_full = 1'b1;
        for (int k = 0; k < NCH; k++) send(32'h20 + k, 1'b0);
        s_valid = 1'b1;            // must be ignored while not ready
        s_data = 32'hDEAD_BEEF;
        s_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("t2_hold_wrreq", ff_wrreq, 0);
            check("t2_hold_ready", s_ready, 0);
            check("t2_hold_wdata", ff_wdata, pix(32'h20, 1));
            step();
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        ff_full = 1'b0;
        #1;
        check("t2_wrreq_on_drop", ff_wrreq, 1);
        step();
        check("t2_ready_back", s_ready, 1);
        check("t2_nwr", n_wr, 2);
        check("t2_pix_count", pix_count, 2);
        check("t2_frame_err", frame_err, 0);

        // ---------------- finish frame with s_last ----------------
        send_pixel(32'h30, 1'b0, "f0p2");
        send_pixel(32'h40, 1'b1, "f0p3");
        check("f0_frame_done", frame_done, 1);
        check("f0_pix_wrap", pix_count, 0);
        check("f0_frame_err", frame_err, 0);
        step();
        check("f0_done_pulse_end", frame_done, 0);
        check("f0_ndone", n_done, 1);

        // ---------------- 3: clean 32-word frame ----------------
        for (int p = 0; p < 4; p++) send_pixel(32'h100 + p * 16, p == 3, "t3");
        check("t3_frame_done", frame_done, 1);
        check("t3_nwr", n_wr, 8);
        check("t3_pix_count", pix_count, 0);
        check("t3_frame_err", frame_err, 0);
        step();
        check("t3_ndone", n_done, 2);

        // ---------------- 4: early s_last ----------------
        send_pixel(32'h200, 1'b0, "t4p0");
        send(32'h210, 1'b0);
        send(32'h211, 1'b0);
        send(32'h212, 1'b1);
        s_valid = 1'b0;
        s_last = 1'b0;
        check("t4_frame_err", frame_err, 1);
        check("t4_pix_clear", pix_count, 0);
        check("t4_no_wrreq", ff_wrreq, 0);
        check("t4_ready", s_ready, 1);
        step();
        check("t4_nwr_partial", n_wr, 9);
        send_pixel(32'hA0, 1'b0, "t4new");
        check("t4_pix_count", pix_count, 1);
        check("t4_ndone", n_done, 2);

        // ---------------- 6: reset mid-pixel ----------------
        for (int k = 0; k < 5; k++) send(32'h300 + k, 1'b0);
        s_valid = 1'b0;
        wr_before = n_wr;
        reset = 1'b1;
        #1;
        check("t6_rst_ready", s_ready, 0);
        check("t6_rst_wrreq", ff_wrreq, 0);
        check("t6_rst_wdata", ff_wdata, 0);
        check("t6_rst_done", frame_done, 0);
        check("t6_rst_err", frame_err, 0);
        check("t6_rst_pix", pix_count, 0);
        repeat (2) step();
        reset = 1'b0;
        step();
        check("t6_no_strobe", n_wr, wr_before);
        for (int k = 0; k < NCH; k++) begin
            s_valid = 1'b0;
            step();
            send(32'hB0 + k, 1'b0);
        end
        s_valid = 1'b0;
        check("t6_wrreq", ff_wrreq, 1);
        check("t6_wdata", ff_wdata, pix(32'hB0, 1));
        step();
        check("t6_nwr", n_wr, wr_before + 1);
        check("t6_pix_count", pix_count, 1);

        // ---------------- 5: missing s_last ----------------
        send_pixel(32'h410, 1'b0, "t5p1");
        send_pixel(32'h420, 1'b0, "t5p2");
        check("t5_err_before", frame_err, 0);
        send_pixel(32'h430, 1'b0, "t5p3");
        check("t5_frame_done", frame_done, 1);
        check("t5_frame_err", frame_err, 1);
        check("t5_pix_wrap", pix_count, 0);
        step();
        check("t5_ndone", n_done, 3);
        check("t5_nwr", n_wr, wr_before + 4);
        check("t5_err_sticky", frame_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
